// File: rtl/alu_sequencer_pkg.sv
// Shared constants for the ALU sequencer: datapath width, ALU function codes,
// FSM state encoding and the latched request record.
package alu_sequencer_pkg;

    localparam int ALU_DATA_W = 16;

    localparam logic [2:0] FN_ZERO  = 3'b000;
    localparam logic [2:0] FN_ADD   = 3'b001;
    localparam logic [2:0] FN_SUB   = 3'b010;
    localparam logic [2:0] FN_RSUB  = 3'b011;
    localparam logic [2:0] FN_AND   = 3'b100;
    localparam logic [2:0] FN_OR    = 3'b101;
    localparam logic [2:0] FN_PASSX = 3'b110;
    localparam logic [2:0] FN_NOP   = 3'b111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_WB    = 2'd3;

    typedef struct packed {
        logic [2:0] op;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [2:0] rt;
        logic       imm_sel;
    } req_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Request handshake and external ALU bus between a requester/ALU (master)
// and the sequencer (slave).
interface alu_sequencer_if #(
    parameter int DATA_W = 16
);
    // A request transfers on a rising edge where req_valid && req_ready. The
    // requester holds req_valid and all req_* fields stable until then;
    // req_ready never depends on req_valid.
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [2:0]        req_rd;
    logic [2:0]        req_rs;
    logic [2:0]        req_rt;
    logic              req_imm_sel;
    logic [DATA_W-1:0] req_imm;

    logic [DATA_W-1:0] alu_x;
    logic [DATA_W-1:0] alu_y;
    logic [2:0]        alu_fsel;
    logic [DATA_W-1:0] alu_z;
    logic              alu_cout;

    modport master (
        output req_valid, req_op, req_rd, req_rs, req_rt, req_imm_sel, req_imm,
        input  req_ready,
        input  alu_x, alu_y, alu_fsel,
        output alu_z, alu_cout
    );

    modport slave (
        input  req_valid, req_op, req_rd, req_rs, req_rt, req_imm_sel, req_imm,
        output req_ready,
        output alu_x, alu_y, alu_fsel,
        input  alu_z, alu_cout
    );

endinterface

// File: rtl/alu_sequencer_regfile8x16.sv
// Eight-entry register file: one synchronous write port, two asynchronous
// read ports and an asynchronous debug read port; R0 always reads as zero.
module regfile8x16 #(
    parameter int DATA_W  = 16,
    parameter int REG_CNT = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_we,
    input  logic [2:0]        i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [2:0]        i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [2:0]        i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b,
    input  logic [2:0]        i_dbg_raddr,
    output logic [DATA_W-1:0] o_dbg_rdata
);

    logic [DATA_W-1:0] r_mem [REG_CNT];

    // Entry 0 is never written, and its read is forced to zero as well.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_CNT; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != 3'd0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a   = (i_raddr_a   == 3'd0) ? '0 : r_mem[i_raddr_a];
    assign o_rdata_b   = (i_raddr_b   == 3'd0) ? '0 : r_mem[i_raddr_b];
    assign o_dbg_rdata = (i_dbg_raddr == 3'd0) ? '0 : r_mem[i_dbg_raddr];

endmodule

// File: rtl/alu_sequencer.sv
// Four-phase sequencer (IDLE/FETCH/EXEC/WB) that reads operands from an 8-entry
// register file, drives an external ALU and writes the result back with flags.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int DATA_W  = ALU_DATA_W,
    parameter int REG_CNT = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    alu_sequencer_if.slave    bus,
    input  logic [2:0]        dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              done,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_n,
    output logic [1:0]        dbg_state
);

    logic [1:0]        r_state;
    req_t              r_req;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_x;
    logic [DATA_W-1:0] r_y;
    logic [DATA_W-1:0] r_res;
    logic              r_cout;
    logic              r_flag_z;
    logic              r_flag_c;
    logic              r_flag_n;

    logic              w_accept;
    logic              w_commit;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;

    // Ready is gated by reset so nothing is offered while reset is held.
    assign bus.req_ready = reset_n && (r_state == ST_IDLE);
    assign w_accept      = bus.req_valid && bus.req_ready;
    assign w_commit      = (r_state == ST_WB) && (r_req.op != FN_NOP);

    regfile8x16 #(
        .DATA_W  (DATA_W),
        .REG_CNT (REG_CNT)
    ) u_regfile (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_we        (w_commit),
        .i_waddr     (r_req.rd),
        .i_wdata     (r_res),
        .i_raddr_a   (r_req.rs),
        .o_rdata_a   (w_rs_data),
        .i_raddr_b   (r_req.rt),
        .o_rdata_b   (w_rt_data),
        .i_dbg_raddr (dbg_raddr),
        .o_dbg_rdata (dbg_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_accept) r_state <= ST_FETCH;
                ST_FETCH: r_state <= ST_EXEC;
                ST_EXEC:  r_state <= ST_WB;
                ST_WB:    r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_req <= '0;
            r_imm <= '0;
        end else if (w_accept) begin
            r_req.op      <= bus.req_op;
            r_req.rd      <= bus.req_rd;
            r_req.rs      <= bus.req_rs;
            r_req.rt      <= bus.req_rt;
            r_req.imm_sel <= bus.req_imm_sel;
            r_imm         <= bus.req_imm;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (r_state == ST_FETCH) begin
            r_x <= r_req.imm_sel ? r_imm : w_rs_data;
            r_y <= w_rt_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_res  <= '0;
            r_cout <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_res  <= bus.alu_z;
            r_cout <= bus.alu_cout;
        end
    end

    // Flags follow every committed result, including writes aimed at R0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flag_z <= 1'b0;
            r_flag_c <= 1'b0;
            r_flag_n <= 1'b0;
        end else if (w_commit) begin
            r_flag_z <= (r_res == '0);
            r_flag_c <= r_cout;
            r_flag_n <= r_res[DATA_W-1];
        end
    end

    assign bus.alu_x    = r_x;
    assign bus.alu_y    = r_y;
    assign bus.alu_fsel = (r_state == ST_EXEC) ? r_req.op : FN_ZERO;

    assign done      = (r_state == ST_WB);
    assign flag_z    = r_flag_z;
    assign flag_c    = r_flag_c;
    assign flag_n    = r_flag_n;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed scenarios pinned with literal
// values, then randomized traffic checked every cycle against a reference model.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [2:0]    dbg_raddr;
    logic [W-1:0]  dbg_rdata;
    logic          done;
    logic          flag_z;
    logic          flag_c;
    logic          flag_n;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    alu_sequencer_if #(.DATA_W(W)) bus ();

    alu_sequencer #(.DATA_W(W), .REG_CNT(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus.slave),
        .dbg_raddr (dbg_raddr),
        .dbg_rdata (dbg_rdata),
        .done      (done),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_n    (flag_n),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- external ALU model ----------------
    function automatic logic [W:0] alu_f(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        case (f)
            3'b001:  return {1'b0, x} + {1'b0, y};
            3'b010:  return {1'b0, x} + {1'b0, ~y} + 17'd1;
            3'b011:  return {1'b0, y} + {1'b0, ~x} + 17'd1;
            3'b100:  return {1'b0, x & y};
            3'b101:  return {1'b0, x | y};
            3'b110:  return {1'b0, x};
            default: return '0;
        endcase
    endfunction

    assign {bus.alu_cout, bus.alu_z} = alu_f(bus.alu_fsel, bus.alu_x, bus.alu_y);

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A transaction is accepted when idle; it commits three edges later.
    logic [W-1:0] m_regs [8];
    logic         m_pend;
    int           m_age;
    logic [2:0]   t_op;
    logic [2:0]   t_rd;
    logic [W-1:0] t_x;
    logic [W-1:0] t_y;
    logic         m_fz;
    logic         m_fc;
    logic         m_fn;
    logic [W:0]   exp_q [$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) m_regs[i] <= '0;
            m_fz   <= 1'b0;
            m_fc   <= 1'b0;
            m_fn   <= 1'b0;
            m_pend <= 1'b0;
            m_age  <= 0;
            exp_q.delete();
        end else if (m_pend) begin
            m_age <= m_age + 1;
            if (m_age == 2) begin
                if (t_op != 3'b111 && exp_q.size() > 0) begin
                    if (t_rd != 3'd0) m_regs[t_rd] <= exp_q[0][W-1:0];
                    m_fz <= (exp_q[0][W-1:0] == '0);
                    m_fn <= exp_q[0][W-1];
                    m_fc <= exp_q[0][W];
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                m_pend <= 1'b0;
            end
        end else if (bus.req_valid) begin
            t_op   <= bus.req_op;
            t_rd   <= bus.req_rd;
            t_x    <= bus.req_imm_sel ? bus.req_imm : m_regs[bus.req_rs];
            t_y    <= m_regs[bus.req_rt];
            exp_q.push_back(alu_f(bus.req_op, bus.req_imm_sel ? bus.req_imm : m_regs[bus.req_rs],
                                  m_regs[bus.req_rt]));
            m_pend <= 1'b1;
            m_age  <= 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        #2;
        chk("ready", bus.req_ready, reset_n && !m_pend);
        chk("done", done, m_pend && (m_age == 2));
        chk("alu_fsel", bus.alu_fsel, (m_pend && m_age == 1) ? t_op : 3'b000);
        if (m_pend && m_age >= 1) begin
            chk("alu_x", bus.alu_x, t_x);
            chk("alu_y", bus.alu_y, t_y);
        end
        chk("flag_z", flag_z, m_fz);
        chk("flag_c", flag_c, m_fc);
        chk("flag_n", flag_n, m_fn);
        chk("dbg_rdata", dbg_rdata, m_regs[dbg_raddr]);
    end

    // ---------------- driver tasks ----------------
    task automatic run_op(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                          input logic [2:0] rt, input logic isel, input logic [W-1:0] imm,
                          output int dn, output int dat);
        int n;
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_op      = op;
        bus.req_rd      = rd;
        bus.req_rs      = rs;
        bus.req_rt      = rt;
        bus.req_imm_sel = isel;
        bus.req_imm     = imm;
        #1;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept_wait", bus.req_ready, 1'b1);
        @(negedge clk);
        bus.req_valid   = 1'b0;
        bus.req_op      = 3'($urandom_range(0, 7));
        bus.req_rd      = 3'($urandom_range(0, 7));
        bus.req_rs      = 3'($urandom_range(0, 7));
        bus.req_rt      = 3'($urandom_range(0, 7));
        bus.req_imm_sel = 1'($urandom_range(0, 1));
        bus.req_imm     = 16'($urandom);
        dn  = 0;
        dat = 0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            if (done) begin
                dn++;
                if (dat == 0) dat = i;
            end
            @(negedge clk);
        end
    endtask

    task automatic peek(input logic [2:0] a, output logic [W-1:0] v);
        dbg_raddr = a;
        #1;
        v = dbg_rdata;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int           dn;
        int           dat;
        int           cnt;
        logic [W-1:0] v;

        bus.req_valid   = 1'b0;
        bus.req_op      = '0;
        bus.req_rd      = '0;
        bus.req_rs      = '0;
        bus.req_rt      = '0;
        bus.req_imm_sel = 1'b0;
        bus.req_imm     = '0;
        dbg_raddr       = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", bus.req_ready, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_fsel", bus.alu_fsel, 3'b000);
        chk("rst_state", dbg_state, ST_IDLE);
        reset_n = 1'b1;

        // immediate pass into R1
        run_op(3'b110, 3'd1, 3'd0, 3'd0, 1'b1, 16'h1234, dn, dat);
        chk("t1_done_cnt", dn, 1);
        chk("t1_done_pos", dat, 3);
        peek(3'd1, v);
        chk("t1_r1", v, 16'h1234);
        chk("t1_fz", flag_z, 1'b0);
        chk("t1_fn", flag_n, 1'b0);

        // add with wrap and carry
        run_op(3'b110, 3'd1, 3'd0, 3'd0, 1'b1, 16'hFFFF, dn, dat);
        run_op(3'b110, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0001, dn, dat);
        run_op(3'b001, 3'd3, 3'd1, 3'd2, 1'b0, 16'hABCD, dn, dat);
        peek(3'd3, v);
        chk("t2_r3", v, 16'h0000);
        chk("t2_fz", flag_z, 1'b1);
        chk("t2_fc", flag_c, 1'b1);
        chk("t2_fn", flag_n, 1'b0);

        // negate via reverse subtract, then nop keeps state
        run_op(3'b110, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0005, dn, dat);
        run_op(3'b011, 3'd4, 3'd1, 3'd0, 1'b0, 16'h7777, dn, dat);
        peek(3'd4, v);
        chk("t3_r4", v, 16'hFFFB);
        chk("t3_fn", flag_n, 1'b1);
        chk("t3_fc", flag_c, 1'b0);
        run_op(3'b111, 3'd4, 3'd1, 3'd1, 1'b1, 16'h0000, dn, dat);
        chk("t3_nop_done", dn, 1);
        peek(3'd4, v);
        chk("t3_nop_r4", v, 16'hFFFB);
        chk("t3_nop_fn", flag_n, 1'b1);
        chk("t3_nop_fz", flag_z, 1'b0);

        // read-after-write on the previous destination
        run_op(3'b001, 3'd1, 3'd1, 3'd1, 1'b0, 16'h0000, dn, dat);
        run_op(3'b010, 3'd6, 3'd0, 3'd1, 1'b1, 16'h0003, dn, dat);
        peek(3'd6, v);
        chk("t4_r6", v, 16'hFFF9);
        chk("t4_fc", flag_c, 1'b0);

        // R0 write discarded, request held continuously
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_op      = 3'b110;
        bus.req_rd      = 3'd0;
        bus.req_imm_sel = 1'b1;
        bus.req_imm     = 16'h00AA;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (bus.req_ready) cnt++;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_ready_cnt", cnt, 4);
        peek(3'd0, v);
        chk("t5_r0", v, 16'h0000);
        chk("t5_fz", flag_z, 1'b0);

        // reset during EXEC of a write to R5
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_op      = 3'b110;
        bus.req_rd      = 3'd5;
        bus.req_imm_sel = 1'b1;
        bus.req_imm     = 16'h5555;
        #1;
        chk("t6_ready", bus.req_ready, 1'b1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("t6_exec_fsel", bus.alu_fsel, 3'b110);
        reset_n = 1'b0;
        cnt = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            if (done) cnt++;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (done) cnt++;
        end
        chk("t6_no_done", cnt, 0);
        peek(3'd5, v);
        chk("t6_r5", v, 16'h0000);
        chk("t6_state", dbg_state, ST_IDLE);
        chk("t6_ready_after", bus.req_ready, 1'b1);

        // randomized traffic; fields change every cycle to exercise latching
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            dbg_raddr       = 3'($urandom_range(0, 7));
            bus.req_valid   = ($urandom_range(0, 3) != 0);
            bus.req_op      = 3'($urandom_range(0, 7));
            bus.req_rd      = 3'($urandom_range(0, 7));
            bus.req_rs      = 3'($urandom_range(0, 7));
            bus.req_rt      = 3'($urandom_range(0, 7));
            bus.req_imm_sel = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0:       bus.req_imm = 16'h0000;
                1:       bus.req_imm = 16'hFFFF;
                2:       bus.req_imm = 16'h8000;
                default: bus.req_imm = 16'($urandom);
            endcase
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (6) @(negedge clk);
        #3;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
